perf_counter_unit: RTL and testbench

Synthesizable profiling block that replaces bench-only hierarchical counters with in-design hardware. It counts total cycles, stall cycles and NUM_EVT generic event pulses (cache ops/hits, mispredicts, ...). It accumulates NUM_OCC occupancy values (reservation-station busy counts) per cycle. A RUN/FROZEN control FSM and a snapshot bank give coherent readout through a one-cycle request/response port.

---
 rtl/perf_pkg.sv | 18 +
 rtl/perf_counter_unit_if.sv | 14 +
 rtl/perf_sat_counter.sv | 34 +++
 rtl/perf_counter_unit.sv | 120 ++++++++++++
 tb/tb_perf_counter_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/perf_pkg.sv
// Shared types and index map for the performance counter unit.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } perf_state_e;

    localparam int IDX_CYCLES   = 0;
    localparam int IDX_STALLS   = 1;
    localparam int IDX_EVT_BASE = 2;

    function automatic int idx_occ_base(input int num_evt);
        return IDX_EVT_BASE + num_evt;
    endfunction

endpackage

// File: rtl/perf_counter_unit_if.sv
// One-cycle request/response readout port of the performance counter unit.
interface perf_counter_unit_if #(
    parameter int SEL_W = 4,
    parameter int ACC_W = 40
);
    logic             rd_req;
    logic [SEL_W-1:0] rd_sel;
    logic             rd_valid;
    logic [ACC_W-1:0] rd_data;
    logic             rd_err;

    modport master (output rd_req, rd_sel, input rd_valid, rd_data, rd_err);
    modport slave  (input rd_req, rd_sel, output rd_valid, rd_data, rd_err);
endinterface

// File: rtl/perf_sat_counter.sv
// Saturating accumulator with a sticky overflow flag; never wraps.
module perf_sat_counter #(
    parameter int W     = 32,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     count,
    output logic             ovf
);
    logic [W:0] sum;

    assign sum = {1'b0, count} + (W+1)'(inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (en) begin
            if (sum[W]) begin
                count <= '1;
                ovf   <= 1'b1;
            end else begin
                count <= sum[W-1:0];
            end
        end
    end
endmodule

// File: rtl/perf_counter_unit.sv
// Cycle/stall/event counters and occupancy accumulators with a RUN/FROZEN
// control FSM, a snapshot bank and a registered read port.
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int NUM_EVT = 4,
    parameter int NUM_OCC = 3,
    parameter int OCC_W   = 4,
    parameter int CNT_W   = 32,
    parameter int ACC_W   = 40,
    parameter int NUM_CNT = 2 + NUM_EVT + NUM_OCC,
    parameter int SEL_W   = $clog2(NUM_CNT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     halt,
    input  logic                     clear,
    input  logic                     snap,
    input  logic                     issue_valid,
    input  logic [NUM_EVT-1:0]       evt,
    input  logic [NUM_OCC*OCC_W-1:0] occ,
    perf_counter_unit_if.slave       rd_bus,
    output logic [1:0]               state_o,
    output logic [NUM_CNT-1:0]       ovf
);
    localparam int OCC_BASE = idx_occ_base(NUM_EVT);

    perf_state_e        state;
    logic               count_en;
    logic               do_snap;
    logic               snap_pend;
    logic               sel_ok;
    logic [NUM_EVT+1:0] bit_inc;
    logic [ACC_W-1:0]   live   [NUM_CNT];
    logic [ACC_W-1:0]   shadow [NUM_CNT];
    logic [ACC_W-1:0]   rd_src;

    assign count_en = (state == RUN);
    assign do_snap  = snap | ((state == RUN) & halt);
    assign bit_inc  = {evt, ~issue_valid, 1'b1};
    assign sel_ok   = rd_bus.rd_sel < SEL_W'(NUM_CNT);
    assign state_o  = state;

    for (genvar i = 0; i < 2 + NUM_EVT; i++) begin : g_bit
        logic [CNT_W-1:0] cnt;
        perf_sat_counter #(.W(CNT_W), .INC_W(1)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (clear),
            .en    (count_en),
            .inc   (bit_inc[i]),
            .count (cnt),
            .ovf   (ovf[i])
        );
        assign live[i] = ACC_W'(cnt);
    end

    for (genvar j = 0; j < NUM_OCC; j++) begin : g_occ
        perf_sat_counter #(.W(ACC_W), .INC_W(OCC_W)) u_acc (
            .clk   (clk),
            .rst   (rst),
            .clr   (clear),
            .en    (count_en),
            .inc   (occ[j*OCC_W +: OCC_W]),
            .count (live[OCC_BASE+j]),
            .ovf   (ovf[OCC_BASE+j])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= RUN;
                RUN:     if (halt)  state <= FROZEN;
                FROZEN:  if (start) state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    // A snapshot is taken lazily: the edge after snap the live counters
    // already hold the snapped (post-increment) values, so they are copied
    // then, and reads in that one cycle are served from the live values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_pend <= 1'b0;
            for (int k = 0; k < NUM_CNT; k++) shadow[k] <= '0;
        end else if (clear) begin
            snap_pend <= 1'b0;
            for (int k = 0; k < NUM_CNT; k++) shadow[k] <= '0;
        end else begin
            snap_pend <= do_snap;
            if (snap_pend) begin
                for (int k = 0; k < NUM_CNT; k++) shadow[k] <= live[k];
            end
        end
    end

    always_comb begin
        rd_src = '0;
        if (sel_ok) rd_src = snap_pend ? live[rd_bus.rd_sel] : shadow[rd_bus.rd_sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bus.rd_valid <= 1'b0;
            rd_bus.rd_err   <= 1'b0;
            rd_bus.rd_data  <= '0;
        end else begin
            rd_bus.rd_valid <= rd_bus.rd_req;
            rd_bus.rd_err   <= rd_bus.rd_req & ~sel_ok;
            rd_bus.rd_data  <= (rd_bus.rd_req & sel_ok) ? rd_src : '0;
        end
    end
endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit with a 4-bit counter width so saturation is reachable.
module tb_perf_counter_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, halt, clear, snap, issue_valid;
    logic [3:0]  evt;
    logic [11:0] occ;
    logic [1:0]  state_o;
    logic [8:0]  ovf;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          sel;
        logic [63:0] data;
        logic        err;
    } rd_vec_t;

    rd_vec_t tbl [7];

    perf_counter_unit_if #(.SEL_W(4), .ACC_W(40)) bus ();

    perf_counter_unit #(
        .NUM_EVT (4),
        .NUM_OCC (3),
        .OCC_W   (4),
        .CNT_W   (4),
        .ACC_W   (40)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt        (halt),
        .clear       (clear),
        .snap        (snap),
        .issue_valid (issue_valid),
        .evt         (evt),
        .occ         (occ),
        .rd_bus      (bus),
        .state_o     (state_o),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic rd(input int sel, input logic [63:0] exp_d, input logic exp_e, input string name);
        bus.rd_req = 1'b1;
        bus.rd_sel = 4'(sel);
        step();
        bus.rd_req = 1'b0;
        check({name, "_vld"}, 64'(bus.rd_valid), 64'(1));
        check({name, "_dat"}, 64'(bus.rd_data), exp_d);
        check({name, "_err"}, 64'(bus.rd_err), 64'(exp_e));
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        tbl[0] = '{0, 64'd11, 1'b0};
        tbl[1] = '{1, 64'd3,  1'b0};
        tbl[2] = '{9, 64'd0,  1'b1};
        tbl[3] = '{4, 64'd0,  1'b0};
        tbl[4] = '{15, 64'd0, 1'b1};
        tbl[5] = '{0, 64'd11, 1'b0};
        tbl[6] = '{8, 64'd0,  1'b0};

        rst = 1'b1;
        start = 1'b0; halt = 1'b0; clear = 1'b0; snap = 1'b0;
        issue_valid = 1'b1; evt = '0; occ = '0;
        bus.rd_req = 1'b0; bus.rd_sel = '0;
        #12;
        check("rst_state", 64'(state_o), 64'(0));
        check("rst_vld",   64'(bus.rd_valid), 64'(0));
        check("rst_dat",   64'(bus.rd_data), 64'(0));
        check("rst_err",   64'(bus.rd_err), 64'(0));
        check("rst_ovf",   64'(ovf), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // 10 run cycles with 3 stalls, then halt: halt edge is counted
        pulse_start();
        check("t1_run", 64'(state_o), 64'(1));
        for (int c = 0; c < 10; c++) begin
            issue_valid = (c == 2 || c == 5 || c == 7) ? 1'b0 : 1'b1;
            step();
        end
        issue_valid = 1'b1;
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("t1_frozen", 64'(state_o), 64'(2));
        check("t1_ovf", 64'(ovf), 64'(0));

        bus.rd_req = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.rd_sel = 4'(tbl[k].sel);
            step();
            check($sformatf("tbl%0d_vld", k), 64'(bus.rd_valid), 64'(1));
            check($sformatf("tbl%0d_dat", k), 64'(bus.rd_data), tbl[k].data);
            check($sformatf("tbl%0d_err", k), 64'(bus.rd_err), 64'(tbl[k].err));
        end
        bus.rd_req = 1'b0;
        step();
        check("tbl_vld_drop", 64'(bus.rd_valid), 64'(0));

        // snap mid-run, snap coinciding with a read returns the old shadow
        pulse_clear();
        check("t2_idle", 64'(state_o), 64'(0));
        pulse_start();
        evt = 4'b0100;
        for (int c = 0; c < 5; c++) step();
        evt = 4'b0000;
        snap = 1'b1;
        step();
        snap = 1'b0;
        evt = 4'b0100;
        for (int c = 0; c < 4; c++) step();
        evt = 4'b0000;
        rd(4, 64'd5, 1'b0, "t2_first");
        snap = 1'b1;
        rd(4, 64'd5, 1'b0, "t2_snap_rd");
        snap = 1'b0;
        rd(4, 64'd9, 1'b0, "t2_second");

        // occupancy accumulation over 8 cycles, halt edge with occ at zero
        pulse_clear();
        pulse_start();
        occ = 12'h251;
        for (int c = 0; c < 8; c++) step();
        occ = '0;
        halt = 1'b1;
        step();
        halt = 1'b0;
        rd(6, 64'd8,  1'b0, "t3_occ0");
        rd(7, 64'd40, 1'b0, "t3_occ1");
        rd(8, 64'd16, 1'b0, "t3_occ2");
        rd(0, 64'd9,  1'b0, "t3_cycles");

        // event counter saturation and sticky overflow
        pulse_clear();
        pulse_start();
        evt = 4'b0001;
        for (int c = 0; c < 20; c++) step();
        evt = '0;
        halt = 1'b1;
        step();
        halt = 1'b0;
        rd(2, 64'd15, 1'b0, "t4_sat");
        check("t4_ovf2", 64'(ovf[2]), 64'(1));
        check("t4_ovf3", 64'(ovf[3]), 64'(0));
        check("t4_ovf0", 64'(ovf[0]), 64'(1));
        pulse_clear();
        check("t4_ovf_clr", 64'(ovf), 64'(0));
        rd(2, 64'd0, 1'b0, "t4_clr_rd");

        // clear, start and halt on the same edge while running
        pulse_start();
        issue_valid = 1'b0;
        for (int c = 0; c < 3; c++) step();
        snap = 1'b1;
        step();
        snap = 1'b0;
        issue_valid = 1'b1;
        clear = 1'b1; start = 1'b1; halt = 1'b1;
        step();
        clear = 1'b0; start = 1'b0; halt = 1'b0;
        check("t5_idle", 64'(state_o), 64'(0));
        rd(0, 64'd0, 1'b0, "t5_cyc");
        rd(1, 64'd0, 1'b0, "t5_stl");

        // asynchronous reset in the middle of a cycle
        pulse_start();
        step();
        step();
        check("t6_run", 64'(state_o), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("t6_async_state", 64'(state_o), 64'(0));
        check("t6_async_ovf", 64'(ovf), 64'(0));
        #1 rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
